// File: rtl/cic_decimator.sv
// rtl/cic_decimator.sv - power-of-two CIC decimator with unity DC gain
//
// Purpose:
//   N-stage CIC decimator (differential delay 1) placed after the IIR notch
//   chain. Emits one sample per 2^k accepted inputs, k = min(dec_log2, MAX).
//   The R^N gain is removed with a rounded (half-up) arithmetic right shift.
//   A registered bypass path passes samples through with one cycle of latency.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   valid_in   in   input sample strobe
//   cic_in     in   signed input sample (DATA_WIDTH)
//   bypass     in   1 = register cic_in straight to cic_out
//   dec_log2   in   log2 of decimation ratio, clamped to MAX_DEC_LOG2
//   cic_out    out  signed decimated sample, held between strobes
//   valid_out  out  one-cycle strobe qualifying cic_out

module cic_decimator #(
  parameter int DATA_WIDTH   = 16,
  parameter int DATA_FRAC    = 15,
  parameter int NUM_STAGES   = 3,
  parameter int MAX_DEC_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] cic_in,
  input  logic                  bypass,
  input  logic [2:0]            dec_log2,
  output logic [DATA_WIDTH-1:0] cic_out,
  output logic                  valid_out
);

  localparam int ACC_WIDTH = DATA_WIDTH + NUM_STAGES * MAX_DEC_LOG2;
  localparam int CW        = MAX_DEC_LOG2 + 1;

  if (NUM_STAGES < 1 || NUM_STAGES > 5 || DATA_FRAC >= DATA_WIDTH) begin : g_bad_params
    $error("cic_decimator: illegal parameter set");
  end

  logic [2:0]                  dec_q;
  logic [CW-1:0]               cnt_q;
  logic                        strobe_q;
  logic signed [ACC_WIDTH-1:0] integ_q [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0] integ_d [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0] dly_q   [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0] comb_c  [NUM_STAGES];

  logic [2:0]                  k_eff;
  logic [CW-1:0]               last_cnt;
  logic [4:0]                  shift_c;
  logic signed [ACC_WIDTH-1:0] round_c;
  logic [DATA_WIDTH-1:0]       y_c;
  logic                        accept;
  logic                        dec_change;
  logic                        complete;

  assign k_eff      = (dec_q > 3'(MAX_DEC_LOG2)) ? 3'(MAX_DEC_LOG2) : dec_q;
  assign last_cnt   = (CW'(1) << k_eff) - CW'(1);
  assign shift_c    = 5'(NUM_STAGES) * {2'b00, k_eff};
  assign accept     = valid_in & ~bypass;
  assign dec_change = (dec_log2 != dec_q);
  assign complete   = accept & ~dec_change & (cnt_q == last_cnt);

  // Non-pipelined integrator cascade: every stage sees this cycle's sum.
  always_comb begin
    integ_d[0] = integ_q[0] + {{(ACC_WIDTH-DATA_WIDTH){cic_in[DATA_WIDTH-1]}}, cic_in};
    for (int i = 1; i < NUM_STAGES; i++) begin
      integ_d[i] = integ_q[i] + integ_d[i-1];
    end
  end

  // Comb chain evaluated combinationally in the strobe cycle.
  always_comb begin
    comb_c[0] = integ_q[NUM_STAGES-1] - dly_q[0];
    for (int i = 1; i < NUM_STAGES; i++) begin
      comb_c[i] = comb_c[i-1] - dly_q[i];
    end
  end

  // Half-LSB offset before the arithmetic shift gives round-half-up.
  assign round_c = (shift_c == 5'd0) ? '0 : (ACC_WIDTH'(1) << (shift_c - 5'd1));
  assign y_c     = DATA_WIDTH'((comb_c[NUM_STAGES-1] + round_c) >>> shift_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q     <= '0;
      cnt_q     <= '0;
      strobe_q  <= 1'b0;
      cic_out   <= '0;
      valid_out <= 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        integ_q[i] <= '0;
        dly_q[i]   <= '0;
      end
    end else begin
      dec_q <= dec_log2;
      if (bypass || dec_change) begin
        // Both cases restart decimation from a clean state; only bypass
        // drives the output, a ratio change just suppresses it.
        cnt_q    <= '0;
        strobe_q <= 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
          integ_q[i] <= '0;
          dly_q[i]   <= '0;
        end
        if (bypass) begin
          cic_out   <= cic_in;
          valid_out <= valid_in;
        end else begin
          valid_out <= 1'b0;
        end
      end else begin
        if (accept) begin
          for (int i = 0; i < NUM_STAGES; i++) begin
            integ_q[i] <= integ_d[i];
          end
          cnt_q <= complete ? '0 : cnt_q + CW'(1);
        end
        strobe_q  <= complete;
        valid_out <= strobe_q;
        if (strobe_q) begin
          cic_out  <= y_c;
          dly_q[0] <= integ_q[NUM_STAGES-1];
          for (int i = 1; i < NUM_STAGES; i++) begin
            dly_q[i] <= comb_c[i-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// tb/tb_cic_decimator.sv - randomized self-checking bench for cic_decimator

module tb_cic_decimator;

  localparam int DW   = 16;
  localparam int NST  = 3;
  localparam int MAXK = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [DW-1:0] cic_in;
  logic          bypass;
  logic [2:0]    dec_log2;
  logic [DW-1:0] cic_out;
  logic          valid_out;

  always #5 clk = ~clk;

  cic_decimator #(
    .DATA_WIDTH  (DW),
    .DATA_FRAC   (15),
    .NUM_STAGES  (NST),
    .MAX_DEC_LOG2(MAXK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .cic_in   (cic_in),
    .bypass   (bypass),
    .dec_log2 (dec_log2),
    .cic_out  (cic_out),
    .valid_out(valid_out)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: samples accepted since the last flush, the
  // registered ratio, one group result waiting to appear, expected outputs.
  int            hist[$];
  int            acc_cnt;
  logic [2:0]    m_copy;
  logic          pend_v;
  logic [DW-1:0] pend_d;
  logic          exp_v;
  logic [DW-1:0] exp_out;
  int            cyc;
  int            seg_start;
  int            first_vo;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Group output = input history convolved with the CIC impulse response
  // (boxcar of length R convolved with itself N times), divided by R^N
  // with round-half-up.
  function automatic logic [DW-1:0] ref_out(input int k);
    longint h[$];
    longint nh[$];
    longint sum;
    int     r;
    int     s;
    r = 1 << k;
    h = {1};
    for (int st = 0; st < NST; st++) begin
      nh = {};
      for (int i = 0; i < h.size() + r - 1; i++) nh.push_back(0);
      for (int i = 0; i < h.size(); i++)
        for (int j = 0; j < r; j++) nh[i+j] += h[i];
      h = nh;
    end
    sum = 0;
    for (int j = 0; j < h.size() && j < hist.size(); j++)
      sum += h[j] * longint'(hist[hist.size()-1-j]);
    s = NST * k;
    if (s > 0) sum = (sum + (longint'(1) <<< (s - 1))) >>> s;
    return sum[DW-1:0];
  endfunction

  task automatic model_clear();
    hist    = {};
    acc_cnt = 0;
    pend_v  = 1'b0;
  endtask

  task automatic step(input logic v, input logic [DW-1:0] x, input logic byp, input logic [2:0] dec);
    logic          nv;
    logic [DW-1:0] nout;
    logic          new_v;
    logic [DW-1:0] new_d;
    int            k;
    valid_in = v;
    cic_in   = x;
    bypass   = byp;
    dec_log2 = dec;
    nv    = 1'b0;
    nout  = exp_out;
    new_v = 1'b0;
    new_d = '0;
    if (byp) begin
      nv   = v;
      nout = x;
      model_clear();
    end else if (dec != m_copy) begin
      model_clear();
    end else begin
      k = (dec > 3'(MAXK)) ? MAXK : int'(dec);
      if (pend_v) begin
        nv   = 1'b1;
        nout = pend_d;
      end
      if (v) begin
        hist.push_back(int'($signed(x)));
        if (hist.size() > 64) void'(hist.pop_front());
        acc_cnt++;
        if (acc_cnt % (1 << k) == 0) begin
          new_v = 1'b1;
          new_d = ref_out(k);
        end
      end
    end
    m_copy = dec;
    pend_v = new_v;
    pend_d = new_d;
    @(posedge clk);
    #1;
    cyc++;
    exp_v   = nv;
    exp_out = nout;
    check_eq("valid_out", {31'b0, valid_out}, {31'b0, exp_v});
    check_eq("cic_out", {16'b0, cic_out}, {16'b0, exp_out});
    if (valid_out && first_vo < 0) first_vo = cyc - seg_start;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", {31'b0, valid_out}, 32'd0);
    check_eq("rst_async_data", {16'b0, cic_out}, 32'd0);
    for (int i = 0; i < n; i++) begin
      valid_in = i[0];
      cic_in   = DW'($urandom);
      @(posedge clk);
      #1;
      cyc++;
      check_eq("rst_valid", {31'b0, valid_out}, 32'd0);
      check_eq("rst_data", {16'b0, cic_out}, 32'd0);
    end
    rst_n    = 1'b1;
    valid_in = 1'b0;
    model_clear();
    m_copy  = '0;
    exp_v   = 1'b0;
    exp_out = '0;
  endtask

  initial begin
    logic byp_st;
    logic [2:0] dec_st;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    cic_in   = '0;
    bypass   = 1'b0;
    dec_log2 = 3'd2;
    cyc      = 0;
    first_vo = -1;
    seg_start = 0;
    model_clear();
    m_copy  = '0;
    exp_v   = 1'b0;
    exp_out = '0;

    do_reset(5);

    // Constant inputs, R=4: first strobe 2 cycles after the 4th sample.
    step(1'b0, '0, 1'b0, 3'd2);
    seg_start = cyc;
    first_vo  = -1;
    repeat (40) step(1'b1, 16'h4000, 1'b0, 3'd2);
    check_eq("t2_first_out_cycle", first_vo, 32'd5);
    check_eq("t2_settled_pos", {16'b0, cic_out}, 32'h4000);
    repeat (40) step(1'b1, 16'h8000, 1'b0, 3'd2);
    check_eq("t2_settled_neg", {16'b0, cic_out}, 32'h8000);

    // R=1 identity on a ramp.
    step(1'b0, '0, 1'b0, 3'd0);
    for (int i = 1; i <= 30; i++) step(1'b1, DW'(i), 1'b0, 3'd0);
    check_eq("t3_ramp_delay", {16'b0, cic_out}, 32'd29);

    // R=8 with valid every other cycle.
    step(1'b0, '0, 1'b0, 3'd3);
    for (int i = 0; i < 100; i++) step(i % 2 == 0, 16'hC000, 1'b0, 3'd3);
    check_eq("t4_settled", {16'b0, cic_out}, 32'hC000);

    // Mid-group ratio change aborts the group.
    step(1'b0, '0, 1'b0, 3'd2);
    repeat (6) step(1'b1, DW'($urandom), 1'b0, 3'd2);
    step(1'b1, DW'($urandom), 1'b0, 3'd1);
    seg_start = cyc;
    first_vo  = -1;
    repeat (2) step(1'b1, DW'($urandom), 1'b0, 3'd1);
    repeat (2) step(1'b0, '0, 1'b0, 3'd1);
    check_eq("t5_next_out_cycle", first_vo, 32'd3);
    repeat (60) step($urandom_range(0, 2) != 0, DW'($urandom), 1'b0, 3'd1);

    // Bypass, then restart with R=2.
    step(1'b1, 16'h1234, 1'b1, 3'd1);
    check_eq("t6_bypass_data", {16'b0, cic_out}, 32'h1234);
    check_eq("t6_bypass_valid", {31'b0, valid_out}, 32'd1);
    repeat (8) step($urandom_range(0, 1) == 1, DW'($urandom), 1'b1, 3'd1);
    seg_start = cyc;
    first_vo  = -1;
    repeat (6) step(1'b1, DW'($urandom), 1'b0, 3'd1);
    check_eq("t6_restart_cycle", first_vo, 32'd3);

    // Random mix: gaps, ratio changes (including clamped values), bypass
    // bursts and a reset in the middle of a group.
    byp_st = 1'b0;
    dec_st = 3'd2;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 39) == 0) dec_st = 3'($urandom);
      if ($urandom_range(0, 29) == 0) byp_st = ~byp_st;
      if (i == 600) do_reset(3);
      step($urandom_range(0, 3) != 0, DW'($urandom), byp_st, dec_st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
